// File: rtl/gpio_port_irq.sv
// gpio_port_irq: memory-mapped GPIO port with per-bit direction, atomic set/clear,
// synchronised inputs and per-bit edge interrupts with write-1-to-clear status.
`default_nettype none

module gpio_port_irq #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Address,
  input  logic [31:0]      DataIn,
  output logic [31:0]      DataOut,
  input  logic             Select,
  input  logic             WriteEn,
  input  logic [WIDTH-1:0] GPIO_Port_In,
  output logic [WIDTH-1:0] GPIO_Port_Out,
  output logic [WIDTH-1:0] GPIO_Port_Oe,
  output logic             Irq
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_IN     = 3'd1;
  localparam logic [2:0] ADDR_DIR    = 3'd2;
  localparam logic [2:0] ADDR_IEN    = 3'd3;
  localparam logic [2:0] ADDR_EDGE   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_SET    = 3'd6;
  localparam logic [2:0] ADDR_CLR    = 3'd7;

  logic [2:0]       addr;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] evt;

  logic [WIDTH-1:0] out_q,    out_d;
  logic [WIDTH-1:0] dir_q,    dir_d;
  logic [WIDTH-1:0] ien_q,    ien_d;
  logic [WIDTH-1:0] edge_q,   edge_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_sel;

  logic unused_bits;

  assign addr        = Address[4:2];
  assign wr_en       = Select & WriteEn;
  assign wdata       = DataIn[WIDTH-1:0];
  assign unused_bits = ^{Address[31:5], Address[1:0], DataIn};

  assign sync = sync_q[SYNC_STAGES-1];

  // Polarity comes from the registered EDGE value, so an EDGE write only
  // affects events evaluated at later edges.
  for (genvar i = 0; i < WIDTH; i++) begin : g_evt
    assign evt[i] = edge_q[i] ? (sync[i] & ~prev_q[i]) : (~sync[i] & prev_q[i]);
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    ien_d    = ien_q;
    edge_d   = edge_q;
    clr_mask = '0;
    if (wr_en) begin
      case (addr)
        ADDR_OUT:    out_d    = wdata;
        ADDR_DIR:    dir_d    = wdata;
        ADDR_IEN:    ien_d    = wdata;
        ADDR_EDGE:   edge_d   = wdata;
        ADDR_STATUS: clr_mask = wdata;
        ADDR_SET:    out_d    = out_q | wdata;
        ADDR_CLR:    out_d    = out_q & ~wdata;
        default:     ;
      endcase
    end
    // Event set takes priority over a same-edge write-1-to-clear.
    status_d = (status_q & ~clr_mask) | evt;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      out_q    <= RST_OUT;
      dir_q    <= '0;
      ien_q    <= '0;
      edge_q   <= '1;
      status_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], GPIO_Port_In};
      prev_q   <= sync;
      out_q    <= out_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      edge_q   <= edge_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rd_sel = '0;
    case (addr)
      ADDR_OUT:    rd_sel = out_q;
      ADDR_IN:     rd_sel = sync;
      ADDR_DIR:    rd_sel = dir_q;
      ADDR_IEN:    rd_sel = ien_q;
      ADDR_EDGE:   rd_sel = edge_q;
      ADDR_STATUS: rd_sel = status_q;
      ADDR_SET:    rd_sel = '0;
      ADDR_CLR:    rd_sel = '0;
      default:     rd_sel = '0;
    endcase
    DataOut = '0;
    if (Select) begin
      DataOut[WIDTH-1:0] = rd_sel;
    end
  end

  assign GPIO_Port_Out = out_q;
  assign GPIO_Port_Oe  = dir_q;
  assign Irq           = |(status_q & ien_q);

endmodule

`default_nettype wire

// File: tb/tb_gpio_port_irq.sv
// Directed self-checking bench for gpio_port_irq: an 8-bit instance with the
// default synchroniser and a 32-bit instance with a three-stage synchroniser.
`default_nettype none

module tb_gpio_port_irq;

  localparam logic [2:0] A_OUT = 3'd0, A_IN = 3'd1, A_DIR = 3'd2, A_IEN = 3'd3;
  localparam logic [2:0] A_EDGE = 3'd4, A_STAT = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        WriteEn;
  logic        sel8, sel32;
  logic [31:0] dout8, dout32;
  logic [7:0]  pins8;
  logic [7:0]  pout8, poe8;
  logic        irq8;
  logic [31:0] pins32;
  logic [31:0] pout32, poe32;
  logic        irq32;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_port_irq #(.WIDTH(8), .SYNC_STAGES(2), .RST_OUT(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn), .DataOut(dout8),
    .Select(sel8), .WriteEn(WriteEn), .GPIO_Port_In(pins8),
    .GPIO_Port_Out(pout8), .GPIO_Port_Oe(poe8), .Irq(irq8)
  );

  gpio_port_irq #(.WIDTH(32), .SYNC_STAGES(3)) dut32 (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn), .DataOut(dout32),
    .Select(sel32), .WriteEn(WriteEn), .GPIO_Port_In(pins32),
    .GPIO_Port_Out(pout32), .GPIO_Port_Oe(poe32), .Irq(irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit d32, input logic [2:0] a, input logic [31:0] v);
    @(posedge clk);
    Address = {27'b0, a, 2'b00};
    DataIn  = v;
    WriteEn = 1'b1;
    if (d32) sel32 = 1'b1; else sel8 = 1'b1;
    @(negedge clk);
    #1;
    WriteEn = 1'b0;
    sel8    = 1'b0;
    sel32   = 1'b0;
  endtask

  task automatic rchk(input string tag, input bit d32, input logic [2:0] a,
                      input logic [31:0] exp);
    logic [31:0] v;
    Address = {27'b0, a, 2'b00};
    if (d32) sel32 = 1'b1; else sel8 = 1'b1;
    #1;
    v = d32 ? dout32 : dout8;
    sel8  = 1'b0;
    sel32 = 1'b0;
    check(tag, v, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Address = '0; DataIn = '0; WriteEn = 1'b0;
    sel8 = 1'b0; sel32 = 1'b0; pins8 = '0; pins32 = '0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    edges(2);

    // Reset values
    check("rst_pout", {24'b0, pout8}, 32'hA5);
    check("rst_poe",  {24'b0, poe8},  32'h00);
    check("rst_irq",  {31'b0, irq8},  32'h0);
    rchk("rst_out",  0, A_OUT,  32'hA5);
    rchk("rst_in",   0, A_IN,   32'h00);
    rchk("rst_dir",  0, A_DIR,  32'h00);
    rchk("rst_ien",  0, A_IEN,  32'h00);
    rchk("rst_edge", 0, A_EDGE, 32'hFF);
    rchk("rst_stat", 0, A_STAT, 32'h00);
    rchk("rst_set",  0, A_SET,  32'h00);
    rchk("rst_clr",  0, A_CLR,  32'h00);
    Address = {27'b0, A_EDGE, 2'b00};
    #1;
    check("unsel_rd", dout8, 32'h0);

    // Output path
    wr(0, A_DIR, 32'h0F);
    check("dir_oe", {24'b0, poe8}, 32'h0F);
    wr(0, A_OUT, 32'h30);
    check("out_wr", {24'b0, pout8}, 32'h30);
    wr(0, A_SET, 32'h05);
    check("out_set", {24'b0, pout8}, 32'h35);
    wr(0, A_CLR, 32'h21);
    check("out_clr", {24'b0, pout8}, 32'h14);
    rchk("rd_set", 0, A_SET, 32'h00);
    rchk("rd_clr", 0, A_CLR, 32'h00);
    rchk("rd_out", 0, A_OUT, 32'h14);

    // Rising-edge interrupt on pin0
    wr(0, A_IEN, 32'h01);
    wr(0, A_EDGE, 32'h01);
    @(posedge clk); pins8[0] = 1'b1;
    edges(1);
    rchk("rise_in_n", 0, A_IN, 32'h00);
    edges(1);
    rchk("rise_in_n1", 0, A_IN, 32'h01);
    rchk("rise_st_n1", 0, A_STAT, 32'h00);
    check("rise_irq_n1", {31'b0, irq8}, 32'h0);
    edges(1);
    rchk("rise_st_n2", 0, A_STAT, 32'h01);
    check("rise_irq_n2", {31'b0, irq8}, 32'h1);
    wr(0, A_STAT, 32'h01);
    check("w1c_irq", {31'b0, irq8}, 32'h0);
    rchk("w1c_st", 0, A_STAT, 32'h00);

    // Falling edge on pin1, IEN gating
    @(posedge clk); pins8[1] = 1'b1;
    edges(4);
    rchk("fall_norise", 0, A_STAT, 32'h00);
    wr(0, A_EDGE, 32'hFD);
    wr(0, A_IEN, 32'h00);
    @(posedge clk); pins8[1] = 1'b0;
    edges(3);
    rchk("fall_st", 0, A_STAT, 32'h02);
    check("fall_gated", {31'b0, irq8}, 32'h0);
    wr(0, A_IEN, 32'h02);
    check("fall_ien", {31'b0, irq8}, 32'h1);
    wr(0, A_STAT, 32'h02);
    check("fall_clr", {31'b0, irq8}, 32'h0);

    // Event and W1C on bit 2 at the same edge: set wins
    wr(0, A_IEN, 32'h04);
    @(posedge clk); pins8[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(0, A_STAT, 32'h04);
    rchk("simul_st", 0, A_STAT, 32'h04);
    check("simul_irq", {31'b0, irq8}, 32'h1);
    wr(0, A_STAT, 32'h04);
    check("simul_clr", {31'b0, irq8}, 32'h0);

    // Asynchronous reset with STATUS=FF and OUT=FF
    @(posedge clk); pins8 = 8'h00;
    edges(4);
    rchk("pre_quiet", 0, A_STAT, 32'h00);
    wr(0, A_EDGE, 32'hFF);
    wr(0, A_IEN, 32'hFF);
    wr(0, A_SET, 32'hFF);
    check("pre_out", {24'b0, pout8}, 32'hFF);
    @(posedge clk); pins8 = 8'hFF;
    edges(3);
    rchk("pre_st", 0, A_STAT, 32'hFF);
    check("pre_irq", {31'b0, irq8}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pout", {24'b0, pout8}, 32'hA5);
    check("arst_poe",  {24'b0, poe8},  32'h00);
    check("arst_irq",  {31'b0, irq8},  32'h0);
    rchk("arst_st", 0, A_STAT, 32'h00);
    repeat (2) @(posedge clk);
    rst = 1'b0;
    edges(2);
    rchk("rel_st_e2", 0, A_STAT, 32'h00);
    edges(1);
    rchk("rel_st_e3", 0, A_STAT, 32'hFF);
    check("rel_irq", {31'b0, irq8}, 32'h0);

    // 32-bit instance, three-stage synchroniser, bit 31
    check("w32_pout", pout32, 32'h0);
    check("w32_poe",  poe32,  32'h0);
    rchk("w32_edge", 1, A_EDGE, 32'hFFFF_FFFF);
    wr(1, A_OUT, 32'hFFFF_0000);
    wr(1, A_CLR, 32'h0F00_0000);
    check("w32_clr", pout32, 32'hF0FF_0000);
    wr(1, A_IEN, 32'h8000_0000);
    @(posedge clk); pins32[31] = 1'b1;
    edges(1);
    rchk("w32_in_n", 1, A_IN, 32'h0);
    edges(1);
    rchk("w32_in_n1", 1, A_IN, 32'h0);
    edges(1);
    rchk("w32_in_n2", 1, A_IN, 32'h8000_0000);
    rchk("w32_st_n2", 1, A_STAT, 32'h0);
    edges(1);
    rchk("w32_st_n3", 1, A_STAT, 32'h8000_0000);
    check("w32_irq_n3", {31'b0, irq32}, 32'h1);
    wr(1, A_STAT, 32'h8000_0000);
    check("w32_clr_irq", {31'b0, irq32}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
